// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: latches VRAM character and attribute bytes on an
// 8-cycle phase schedule, fetches the font row and shifts out 8 coloured
// pixels per character cell onto a 6-bit RGB DAC.
module text_pixel_gen #(
  parameter int unsigned BLINK_BIT = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        v_active_i,
  input  logic        h_begin_active_i,
  input  logic        h_end_active_i,
  input  logic [3:0]  v_count_i,
  input  logic        v_sync_i,
  input  logic [7:0]  vram_data_i,
  input  logic [7:0]  font_data_i,
  output logic [11:0] font_addr_o,
  output logic [1:0]  red_o,
  output logic [1:0]  green_o,
  output logic [1:0]  blue_o
);

  localparam int unsigned FrameW = BLINK_BIT + 1;

  logic              active_q, active_d;
  logic [2:0]        count_q, count_d;
  logic [7:0]        char_q, char_d;
  logic [7:0]        font_q, font_d;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        fg_q, fg_d;
  logic [2:0]        bg_q, bg_d;
  logic              blink_q, blink_d;
  logic [3:0]        pix_left_q, pix_left_d;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic              v_sync_q;
  logic [5:0]        rgb_q, rgb_d;

  logic load;
  logic pix_on;

  // Phase counter: starts at 2 so the char/attr latch points line up with
  // the readout stage's address schedule.
  always_comb begin
    active_d = active_q;
    count_d  = count_q;
    if (!active_q) begin
      if (h_begin_active_i && v_active_i) begin
        active_d = 1'b1;
        count_d  = 3'd2;
      end
    end else begin
      count_d = count_q + 3'd1;
      if (h_end_active_i) begin
        active_d = 1'b0;
      end
    end
  end

  assign load = active_q && (count_q == 3'd7);

  // Character/font latches and the pixel shifter; a load wins over a shift.
  always_comb begin
    char_d     = char_q;
    font_d     = font_q;
    shift_d    = shift_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    blink_d    = blink_q;
    pix_left_d = pix_left_q;
    if (active_q && (count_q == 3'd3)) begin
      char_d = vram_data_i;
    end
    if (active_q && (count_q == 3'd6)) begin
      font_d = font_data_i;
    end
    if (load) begin
      shift_d    = font_q;
      fg_d       = vram_data_i[3:0];
      bg_d       = vram_data_i[6:4];
      blink_d    = vram_data_i[7];
      pix_left_d = 4'd8;
    end else if (pix_left_q != 4'd0) begin
      shift_d    = {shift_q[6:0], 1'b0};
      pix_left_d = pix_left_q - 4'd1;
    end
  end

  // Frame counter advances on each rising edge of vertical sync.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (v_sync_i && !v_sync_q) begin
      frame_cnt_d = frame_cnt_q + FrameW'(1);
    end
  end

  assign pix_on = shift_q[7] & ~(blink_q & frame_cnt_q[BLINK_BIT]);

  // Colour select: foreground carries intensity into each channel LSB,
  // background is always low intensity; blank once the shifter is empty.
  always_comb begin
    rgb_d = 6'd0;
    if (pix_left_q != 4'd0) begin
      if (pix_on) begin
        rgb_d = {fg_q[2], fg_q[3], fg_q[1], fg_q[3], fg_q[0], fg_q[3]};
      end else begin
        rgb_d = {bg_q[2], 1'b0, bg_q[1], 1'b0, bg_q[0], 1'b0};
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      active_q    <= 1'b0;
      count_q     <= 3'd0;
      char_q      <= 8'd0;
      font_q      <= 8'd0;
      shift_q     <= 8'd0;
      fg_q        <= 4'd0;
      bg_q        <= 3'd0;
      blink_q     <= 1'b0;
      pix_left_q  <= 4'd0;
      frame_cnt_q <= '0;
      v_sync_q    <= 1'b0;
      rgb_q       <= 6'd0;
    end else begin
      active_q    <= active_d;
      count_q     <= count_d;
      char_q      <= char_d;
      font_q      <= font_d;
      shift_q     <= shift_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      blink_q     <= blink_d;
      pix_left_q  <= pix_left_d;
      frame_cnt_q <= frame_cnt_d;
      v_sync_q    <= v_sync_i;
      rgb_q       <= rgb_d;
    end
  end

  assign font_addr_o = {char_q, v_count_i};
  assign red_o       = rgb_q[5:4];
  assign green_o     = rgb_q[3:2];
  assign blue_o      = rgb_q[1:0];

endmodule

// File: tb/tb_text_pixel_gen.sv
// Self-checking bench for text_pixel_gen: table-driven single cells, directed
// multi-cell/blink/no-start/reset sequences and randomized lines checked
// against a per-cycle pixel timeline model.
module tb_text_pixel_gen;

  localparam int unsigned BLINK = 4;
  localparam int FrameMod = 1 << (BLINK + 1);

  logic        clk;
  logic        nrst;
  logic        v_active;
  logic        h_begin;
  logic        h_end;
  logic [3:0]  v_count;
  logic        v_sync;
  logic [7:0]  vram_data;
  logic [7:0]  font_data;
  logic [11:0] font_addr;
  logic [1:0]  red, green, blue;

  text_pixel_gen #(.BLINK_BIT(BLINK)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .v_active_i       (v_active),
    .h_begin_active_i (h_begin),
    .h_end_active_i   (h_end),
    .v_count_i        (v_count),
    .v_sync_i         (v_sync),
    .vram_data_i      (vram_data),
    .font_data_i      (font_data),
    .font_addr_o      (font_addr),
    .red_o            (red),
    .green_o          (green),
    .blue_o           (blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ch;
    logic [7:0]  attr;
    logic [7:0]  font;
    logic [3:0]  vc;
    logic [5:0]  fg;
    logic [5:0]  bg;
    logic [11:0] addr;
  } vec_t;

  vec_t        tbl[5];
  logic [7:0]  ln_char[8];
  logic [7:0]  ln_attr[8];
  logic [7:0]  ln_font[8];
  logic [5:0]  ln_fg[8];
  logic [5:0]  ln_bg[8];
  logic [11:0] ln_addr[8];
  logic [3:0]  ln_vc;
  int          m_frames;
  int          total;
  int          bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference colour: channel = 2*colour_bit + intensity (fg) or 2*colour_bit (bg).
  function automatic logic [5:0] model_fg(input logic [7:0] a);
    int i, r, g, b;
    i = int'(a[3]);
    r = 2 * int'(a[2]) + i;
    g = 2 * int'(a[1]) + i;
    b = 2 * int'(a[0]) + i;
    return {r[1:0], g[1:0], b[1:0]};
  endfunction

  function automatic logic [5:0] model_bg(input logic [7:0] a);
    int r, g, b;
    r = 2 * int'(a[6]);
    g = 2 * int'(a[5]);
    b = 2 * int'(a[4]);
    return {r[1:0], g[1:0], b[1:0]};
  endfunction

  function automatic bit blink_phase();
    return ((m_frames >> BLINK) & 1) == 1;
  endfunction

  task automatic fill_cell(input int c, input logic [7:0] ch, input logic [7:0] attr,
                           input logic [7:0] font);
    ln_char[c] = ch;
    ln_attr[c] = attr;
    ln_font[c] = font;
    ln_fg[c]   = model_fg(attr);
    ln_bg[c]   = model_bg(attr);
    ln_addr[c] = {ch, ln_vc};
  endtask

  // Drives one scanline of n cells; pixel k of cell c is expected on the pins
  // in cycle 8 + 8c + k. rst_at >= 0 pulls nrst low in that cycle.
  task automatic run_line(input int n, input int extra, input bit vact, input int rst_at);
    int len, hend, c, k;
    bit on;
    logic [5:0] e;
    len  = 8 + 8 * n + extra;
    hend = 6 + 8 * (n - 1);
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      e = 6'd0;
      if (vact && (rst_at < 0 || t <= rst_at) && t >= 8 && t < 8 + 8 * n) begin
        c  = (t - 8) / 8;
        k  = (t - 8) % 8;
        on = ln_font[c][7-k] && !(ln_attr[c][7] && blink_phase());
        e  = on ? ln_fg[c] : ln_bg[c];
      end
      check("rgb", 32'({red, green, blue}), 32'(e));
      if (rst_at >= 0 && t > rst_at) begin
        check("font_addr_after_reset", 32'(font_addr), 32'({8'h00, ln_vc}));
      end else if (vact && t >= 3) begin
        c = (t - 3) / 8;
        if (c > n - 1) c = n - 1;
        check("font_addr", 32'(font_addr), 32'(ln_addr[c]));
      end
      nrst     = !(rst_at >= 0 && t >= rst_at && t < rst_at + 2);
      h_begin  = (t == 0) ||
                 (t < hend && (rst_at < 0 || t < rst_at) && $urandom_range(0, 3) == 0);
      v_active = vact;
      h_end    = (t == hend);
      v_count  = ln_vc;
      v_sync   = 1'b0;
      vram_data = 8'($urandom);
      font_data = 8'($urandom);
      if (t >= 2 && (t - 2) % 8 == 0 && (t - 2) / 8 < n) vram_data = ln_char[(t - 2) / 8];
      if (t >= 6 && (t - 6) % 8 == 0 && (t - 6) / 8 < n) vram_data = ln_attr[(t - 6) / 8];
      if (t >= 5 && (t - 5) % 8 == 0 && (t - 5) / 8 < n) font_data = ln_font[(t - 5) / 8];
    end
    h_begin = 1'b0;
    h_end   = 1'b0;
    nrst    = 1'b1;
    if (rst_at >= 0) m_frames = 0;
  endtask

  task automatic pulse_vsync(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      check("rgb_idle", 32'({red, green, blue}), 32'd0);
      v_sync = 1'b1;
      @(negedge clk);
      @(negedge clk);
      v_sync = 1'b0;
      @(negedge clk);
      m_frames = (m_frames + 1) % FrameMod;
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    m_frames = 0;

    tbl[0] = '{ch: 8'h41, attr: 8'h1E, font: 8'hA5, vc: 4'h5,
               fg: 6'b11_11_01, bg: 6'b00_00_10, addr: 12'h415};
    tbl[1] = '{ch: 8'hFF, attr: 8'h8F, font: 8'h3C, vc: 4'hF,
               fg: 6'b11_11_11, bg: 6'b00_00_00, addr: 12'hFFF};
    tbl[2] = '{ch: 8'h00, attr: 8'h70, font: 8'h81, vc: 4'h0,
               fg: 6'b00_00_00, bg: 6'b10_10_10, addr: 12'h000};
    tbl[3] = '{ch: 8'h7E, attr: 8'h25, font: 8'h0F, vc: 4'h9,
               fg: 6'b10_00_10, bg: 6'b00_10_00, addr: 12'h7E9};
    tbl[4] = '{ch: 8'h10, attr: 8'h5A, font: 8'hF0, vc: 4'h3,
               fg: 6'b01_11_01, bg: 6'b10_00_10, addr: 12'h103};

    // Reset held for 3 cycles under random inputs.
    nrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v_active  = 1'($urandom);
      h_begin   = 1'($urandom);
      h_end     = 1'($urandom);
      v_count   = 4'($urandom);
      v_sync    = 1'($urandom);
      vram_data = 8'($urandom);
      font_data = 8'($urandom);
      @(negedge clk);
      check("reset_rgb", 32'({red, green, blue}), 32'd0);
      check("reset_font_addr", 32'(font_addr), 32'({8'h00, v_count}));
    end
    h_begin = 1'b0;
    h_end   = 1'b0;
    v_sync  = 1'b0;
    nrst    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v_active  = 1'($urandom);
      vram_data = 8'($urandom);
      @(negedge clk);
      check("post_reset_idle_rgb", 32'({red, green, blue}), 32'd0);
    end

    // Table of single cells with hand-derived colours.
    for (int i = 0; i < 5; i++) begin
      ln_vc      = tbl[i].vc;
      ln_char[0] = tbl[i].ch;
      ln_attr[0] = tbl[i].attr;
      ln_font[0] = tbl[i].font;
      ln_fg[0]   = tbl[i].fg;
      ln_bg[0]   = tbl[i].bg;
      ln_addr[0] = tbl[i].addr;
      run_line(1, 3, 1'b1, -1);
    end

    // Back-to-back cells: no gap between cells.
    ln_vc = 4'h7;
    fill_cell(0, 8'h00, 8'h1E, 8'hFF);
    fill_cell(1, 8'hFF, 8'h2B, 8'h00);
    fill_cell(2, 8'h10, 8'h70, 8'h81);
    run_line(3, 3, 1'b1, -1);

    // Blink: fg white, then blanked to black bg after 16 frames, then back.
    ln_vc      = 4'h2;
    ln_char[0] = 8'h55;
    ln_attr[0] = 8'h8F;
    ln_font[0] = 8'hFF;
    ln_fg[0]   = 6'b11_11_11;
    ln_bg[0]   = 6'b00_00_00;
    ln_addr[0] = 12'h552;
    run_line(1, 3, 1'b1, -1);
    pulse_vsync(16);
    run_line(1, 3, 1'b1, -1);
    pulse_vsync(16);
    run_line(1, 3, 1'b1, -1);

    // No start when vertical active is low.
    run_line(2, 4, 1'b0, -1);

    // Randomized lines with vsync pulses in between.
    for (int l = 0; l < 25; l++) begin
      int n;
      n     = int'($urandom_range(1, 6));
      ln_vc = 4'($urandom);
      for (int c = 0; c < n; c++) begin
        fill_cell(c, 8'($urandom), 8'($urandom), 8'($urandom));
      end
      run_line(n, int'($urandom_range(2, 5)), $urandom_range(0, 4) != 0, -1);
      pulse_vsync(int'($urandom_range(0, 20)));
    end

    // Reset in cycle 11 of an active line, then a clean restart.
    ln_vc = 4'hC;
    fill_cell(0, 8'h3A, 8'h1E, 8'hA5);
    fill_cell(1, 8'hC3, 8'h4F, 8'h5A);
    fill_cell(2, 8'h99, 8'h86, 8'hF0);
    run_line(3, 3, 1'b1, 11);
    fill_cell(0, 8'h21, 8'h3C, 8'h96);
    fill_cell(1, 8'h42, 8'h61, 8'h7E);
    run_line(2, 3, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
